bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares one port of a 1024x16 dual-port SRAM macro between two fabric-side requesters. Uses round-robin arbitration, one access per cycle. Includes a built-in clear sequencer that zero-fills the whole array on command. It sits between user-design logic and the SRAM port-level signals (ADDR/DIN/BM/WEN/MEN/REN/DOUT). Two instances serve ports A and B.

## Interface
Parameters:
- ADDR_W, 10, address width (depth = 2**ADDR_W)
- DATA_W, 16, data and bit-mask width

Ports:
- UserCLK  in  1  single clock; SRAM samples its inputs on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- configured  in  1  fabric configured; while low, no grants are issued and MEN is held 0
- rq0_valid / rq1_valid  in  1  request valid
- rq0_ready / rq1_ready  out  1  request accepted this cycle (comb)
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_W  address
- rq0_wdata / rq1_wdata  in  DATA_W  write data
- rq0_bm / rq1_bm  in  DATA_W  per-bit write mask, 1 = write bit
- rs0_valid / rs1_valid  out  1  read data valid (registered)
- rs0_data / rs1_data  out  DATA_W  read data
- clear_start  in  1  pulse; starts a zero-fill of the whole array
- clear_busy  out  1  clear sequence in progress (registered)
- sram_addr  out  ADDR_W;  sram_din  out  DATA_W;  sram_bm  out  DATA_W
- sram_wen, sram_ren, sram_men  out  1  SRAM controls (comb)
- sram_dout  in  DATA_W  SRAM read data, valid the cycle after a read is sampled

## Operation
- FSM states: IDLE (arbitrate), CLEAR (sweep). Reset state is IDLE.
- IDLE:
  - Eligible requester = rqN_valid && configured && !clear_start.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the one selected by the priority pointer `prio` is granted. After every grant, `prio` is set to the other requester.
  - Granted requester gets rqN_ready=1. The SRAM is driven from that requester's fields with sram_men=1, sram_wen=we, sram_ren=!we.
  - With no grant: sram_men=sram_wen=sram_ren=0, addr/din/bm=0.
- Read response:
  - A granted read sets a registered tag (port id). The next cycle it asserts rsN_valid=1 for one cycle, with rsN_data=sram_dout.
  - Writes produce no response.
  - rs data is passed through from sram_dout, not registered; rsN_data is meaningful only while rsN_valid=1.
- CLEAR:
  - Entered when clear_start=1 in IDLE with configured=1. clear_start has priority over requests arriving in the same cycle; both readys stay 0 that cycle.
  - Counter cnt runs from 0 to 2**ADDR_W-1, one write per cycle: sram_addr=cnt, din=0, bm=all-ones, wen=1, men=1.
  - When cnt reaches its maximum, the FSM returns to IDLE and cnt is reset to 0.
  - rq*_ready=0 throughout. clear_start is ignored while in CLEAR.
- clear_start with configured=0 is ignored.
- If configured falls during CLEAR, the sweep aborts: return to IDLE, cnt=0, men=0 that cycle.
- A read response pending from the cycle before CLEAR entry is still delivered.
- Reset values: state=IDLE, prio=0, cnt=0, rs0_valid=rs1_valid=0, clear_busy=0, tag cleared. All comb SRAM controls evaluate to 0 under reset.

## Timing
- Request handshake: a transfer occurs in cycle T when valid && ready. The SRAM samples at the T→T+1 edge.
- Read latency: rsN_valid is asserted in cycle T+1. One grant per cycle, fully pipelined, with no bubbles between back-to-back reads.
- Requesters hold valid and fields stable until ready; they may drop valid only after a handshake.
- clear_busy rises the cycle after clear_start is accepted and stays high for exactly 2**ADDR_W cycles. The first clear write is in the cycle after acceptance.
- Requests are accepted again on the first cycle clear_busy is low.

## Structure
- Package bram_arb_pkg: state enum (IDLE, CLEAR) and port-id constants.
- Sub-module rr_arb2: two-input round-robin arbiter holding the `prio` register, with outputs grant0/grant1. Everything else lives in bram_port_arbiter.
- The SRAM is external: the bench uses a behavioural 1024x16 model with bit-mask writes and 1-cycle read latency.

## Test plan
- Single requester: rq0 writes 0xBEEF to addr 5 (bm=0xFFFF), then reads addr 5 → rs0_valid one cycle after the read grant, rs0_data=0xBEEF; rs1_valid stays 0.
- Contention: both requesters hold valid reads for 4 cycles (rq0 addr 1, rq1 addr 2) → grants alternate 0,1,0,1 starting with rq0 after reset; each rsN_valid follows its grant by exactly 1 cycle.
- Bit mask: write 0xFFFF to addr 9, then write 0x0000 with bm=0x00F0, then read → 0xFF0F.
- Clear: fill addr 0 and addr 1023 with 0x1234, pulse clear_start together with rq1_valid → rq1_ready=0, clear_busy high for 1024 cycles; afterwards reads of addr 0 and addr 1023 return 0x0000.
- Not configured: configured=0 with rq0_valid=1 and a clear_start pulse → sram_men=0, no ready, no clear. Raising configured grants rq0 in that same cycle.
- Reset mid-clear: assert RESET_N=0 at cycle 300 of a clear → clear_busy=0, rs*_valid=0 and men=0 immediately. After release, the first request is granted to rq0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the BRAM port arbiter.
package bram_arb_pkg;

   // Top-level sequencer states: arbitrate requests, or sweep zeros through the array.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Requester ids, also used as values of the round-robin priority pointer.
   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: the pointer names the favoured requester
// and moves to the other one after every grant.
module rr_arb2
   import bram_arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);

   logic prio;

   // Grant a lone requester outright; on contention follow the pointer.
   always_comb begin
      grant0 = req0 && (!req1 || (prio == PORT0));
      grant1 = req1 && (!req0 || (prio == PORT1));
   end

   // Hand priority to the requester that was not just served.
   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= PORT0;
      end else if (grant0) begin
         prio <= PORT1;
      end else if (grant1) begin
         prio <= PORT0;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one SRAM port between two requesters with round-robin arbitration
// and provides a zero-fill sweep of the whole array on command.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              UserCLK,
   input  logic              RESET_N,
   input  logic              configured,
   input  logic              rq0_valid,
   output logic              rq0_ready,
   input  logic              rq0_we,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [DATA_W-1:0] rq0_wdata,
   input  logic [DATA_W-1:0] rq0_bm,
   input  logic              rq1_valid,
   output logic              rq1_ready,
   input  logic              rq1_we,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [DATA_W-1:0] rq1_wdata,
   input  logic [DATA_W-1:0] rq1_bm,
   output logic              rs0_valid,
   output logic [DATA_W-1:0] rs0_data,
   output logic              rs1_valid,
   output logic [DATA_W-1:0] rs1_data,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   output logic [DATA_W-1:0] sram_bm,
   output logic              sram_wen,
   output logic              sram_ren,
   output logic              sram_men,
   input  logic [DATA_W-1:0] sram_dout
);

   localparam logic [ADDR_W-1:0] CNT_MAX = '1;

   state_t            state, state_d;
   logic [ADDR_W-1:0] cnt, cnt_d;
   logic              req_ok;
   logic              grant0, grant1;
   logic              rd_grant;
   logic              rd_port;

   // Requests compete only in IDLE, when configured, out of reset, and not
   // in a cycle where a clear command takes precedence.
   assign req_ok = RESET_N && configured && !clear_start && (state == IDLE);

   rr_arb2 u_arb (
      .clk    (UserCLK),
      .rst_n  (RESET_N),
      .req0   (rq0_valid && req_ok),
      .req1   (rq1_valid && req_ok),
      .grant0 (grant0),
      .grant1 (grant1)
   );

   assign rq0_ready = grant0;
   assign rq1_ready = grant1;

   // Read tag for this cycle's grant; the response shows up next cycle.
   assign rd_grant = (grant0 && !rq0_we) || (grant1 && !rq1_we);
   assign rd_port  = grant1 ? PORT1 : PORT0;

   // Read data comes straight from the macro; only the valids are registered.
   assign rs0_data   = sram_dout;
   assign rs1_data   = sram_dout;
   assign clear_busy = (state == CLEAR);

   // Next-state, sweep counter and SRAM port drive.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      sram_addr = '0;
      sram_din  = '0;
      sram_bm   = '0;
      sram_wen  = 1'b0;
      sram_ren  = 1'b0;
      sram_men  = 1'b0;
      case (state)
         IDLE: begin
            if (grant0) begin
               sram_addr = rq0_addr;
               sram_din  = rq0_wdata;
               sram_bm   = rq0_bm;
               sram_men  = 1'b1;
               sram_wen  = rq0_we;
               sram_ren  = !rq0_we;
            end else if (grant1) begin
               sram_addr = rq1_addr;
               sram_din  = rq1_wdata;
               sram_bm   = rq1_bm;
               sram_men  = 1'b1;
               sram_wen  = rq1_we;
               sram_ren  = !rq1_we;
            end
            if (RESET_N && configured && clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (!configured) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               sram_addr = cnt;
               sram_bm   = '1;
               sram_wen  = 1'b1;
               sram_men  = 1'b1;
               if (cnt == CNT_MAX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and sweep counter registers.
   always_ff @(posedge UserCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // One-cycle read-response valids, steered by the granted port id.
   always_ff @(posedge UserCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rs0_valid <= 1'b0;
         rs1_valid <= 1'b0;
      end else begin
         rs0_valid <= rd_grant && (rd_port == PORT0);
         rs1_valid <= rd_grant && (rd_port == PORT1);
      end
   end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural bit-masked SRAM.
module tb_bram_port_arbiter;

   logic        UserCLK = 1'b0;
   logic        RESET_N;
   logic        configured;
   logic        rq0_valid, rq0_ready, rq0_we;
   logic [9:0]  rq0_addr;
   logic [15:0] rq0_wdata, rq0_bm;
   logic        rq1_valid, rq1_ready, rq1_we;
   logic [9:0]  rq1_addr;
   logic [15:0] rq1_wdata, rq1_bm;
   logic        rs0_valid, rs1_valid;
   logic [15:0] rs0_data, rs1_data;
   logic        clear_start, clear_busy;
   logic [9:0]  sram_addr;
   logic [15:0] sram_din, sram_bm, sram_dout;
   logic        sram_wen, sram_ren, sram_men;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e;

   logic [15:0] mem [0:1023];

   bram_port_arbiter #(.ADDR_W(10), .DATA_W(16)) dut (
      .UserCLK     (UserCLK),
      .RESET_N     (RESET_N),
      .configured  (configured),
      .rq0_valid   (rq0_valid),
      .rq0_ready   (rq0_ready),
      .rq0_we      (rq0_we),
      .rq0_addr    (rq0_addr),
      .rq0_wdata   (rq0_wdata),
      .rq0_bm      (rq0_bm),
      .rq1_valid   (rq1_valid),
      .rq1_ready   (rq1_ready),
      .rq1_we      (rq1_we),
      .rq1_addr    (rq1_addr),
      .rq1_wdata   (rq1_wdata),
      .rq1_bm      (rq1_bm),
      .rs0_valid   (rs0_valid),
      .rs0_data    (rs0_data),
      .rs1_valid   (rs1_valid),
      .rs1_data    (rs1_data),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .sram_addr   (sram_addr),
      .sram_din    (sram_din),
      .sram_bm     (sram_bm),
      .sram_wen    (sram_wen),
      .sram_ren    (sram_ren),
      .sram_men    (sram_men),
      .sram_dout   (sram_dout)
   );

   always #5 UserCLK = ~UserCLK;

   always @(posedge UserCLK) cyc <= cyc + 1;

   // Behavioural SRAM: bit-masked write, one-cycle read latency.
   always @(posedge UserCLK) begin
      if (sram_men) begin
         if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
         if (sram_ren) sram_dout <= mem[sram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response must match the oldest expectation for its port.
   always @(negedge UserCLK) begin
      if (rs0_valid) begin
         check("rs0 expected", q0.size() != 0, 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("rs0 data", rs0_data, e.data);
            check("rs0 latency", cyc, e.due);
         end
      end
      if (rs1_valid) begin
         check("rs1 expected", q1.size() != 0, 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("rs1 data", rs1_data, e.data);
            check("rs1 latency", cyc, e.due);
         end
      end
   end

   // Issue one request and wait (bounded) for its handshake.
   task automatic do_req(input bit port, input bit we, input logic [9:0] addr,
                         input logic [15:0] wdata, input logic [15:0] bm,
                         input logic [15:0] expdata);
      bit got = 0;
      @(negedge UserCLK);
      if (port) begin
         rq1_we = we; rq1_addr = addr; rq1_wdata = wdata; rq1_bm = bm; rq1_valid = 1'b1;
      end else begin
         rq0_we = we; rq0_addr = addr; rq0_wdata = wdata; rq0_bm = bm; rq0_valid = 1'b1;
      end
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (port ? rq1_ready : rq0_ready) begin
            got = 1;
            if (!we) begin
               if (port) q1.push_back('{expdata, cyc + 1});
               else      q0.push_back('{expdata, cyc + 1});
            end
         end else begin
            @(negedge UserCLK);
         end
      end
      check(port ? "rq1 handshake" : "rq0 handshake", got, 1);
      @(posedge UserCLK);
      #1;
      if (port) rq1_valid = 1'b0;
      else      rq0_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  bad_ready;
      RESET_N = 1'b0; configured = 1'b1; clear_start = 1'b0;
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_bm = '0;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_bm = '0;

      // Reset state, with requests pending that must stay ungranted.
      #12;
      check("reset men", sram_men, 0);
      check("reset ready0", rq0_ready, 0);
      check("reset ready1", rq1_ready, 0);
      check("reset busy", clear_busy, 0);
      check("reset rs0", rs0_valid, 0);
      check("reset rs1", rs1_valid, 0);
      rq0_valid = 1'b0; rq1_valid = 1'b0;
      @(negedge UserCLK);
      RESET_N = 1'b1;

      // Preload: one grant each leaves the pointer back at rq0.
      do_req(0, 1, 10'd1, 16'h1111, 16'hFFFF, 16'h0);
      do_req(1, 1, 10'd2, 16'h2222, 16'hFFFF, 16'h0);

      // Contention: grants alternate 0,1,0,1.
      @(negedge UserCLK);
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 10'd1;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 10'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("contend ready0", rq0_ready, (i % 2 == 0));
         check("contend ready1", rq1_ready, (i % 2 == 1));
         if (i % 2 == 0) q0.push_back('{16'h1111, cyc + 1});
         else            q1.push_back('{16'h2222, cyc + 1});
         @(negedge UserCLK);
      end
      rq0_valid = 1'b0; rq1_valid = 1'b0;

      // Single requester write then read.
      do_req(0, 1, 10'd5, 16'hBEEF, 16'hFFFF, 16'h0);
      do_req(0, 0, 10'd5, 16'h0, 16'h0, 16'hBEEF);

      // Bit-masked write.
      do_req(0, 1, 10'd9, 16'hFFFF, 16'hFFFF, 16'h0);
      do_req(1, 1, 10'd9, 16'h0000, 16'h00F0, 16'h0);
      do_req(0, 0, 10'd9, 16'h0, 16'h0, 16'hFF0F);

      // Not configured: no grant, no clear; raising configured grants at once.
      @(negedge UserCLK);
      configured = 1'b0; rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 10'd5; clear_start = 1'b1;
      #1;
      check("unconf men", sram_men, 0);
      check("unconf ready0", rq0_ready, 0);
      @(negedge UserCLK);
      clear_start = 1'b0;
      #1;
      check("unconf no clear", clear_busy, 0);
      check("unconf men2", sram_men, 0);
      @(negedge UserCLK);
      configured = 1'b1;
      #1;
      check("conf ready0", rq0_ready, 1);
      check("conf men", sram_men, 1);
      q0.push_back('{16'hBEEF, cyc + 1});
      @(posedge UserCLK);
      #1 rq0_valid = 1'b0;

      // Clear sweep with a competing request.
      do_req(0, 1, 10'd0, 16'h1234, 16'hFFFF, 16'h0);
      do_req(0, 1, 10'd1023, 16'h1234, 16'hFFFF, 16'h0);
      @(negedge UserCLK);
      clear_start = 1'b1; rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 10'd0;
      #1;
      check("clear start ready1", rq1_ready, 0);
      check("clear start men", sram_men, 0);
      @(negedge UserCLK);
      clear_start = 1'b0;
      #1;
      check("clear busy rise", clear_busy, 1);
      check("clear first addr", sram_addr, 0);
      check("clear first wen", sram_wen, 1);
      check("clear first men", sram_men, 1);
      check("clear first din", sram_din, 0);
      check("clear first bm", sram_bm, 16'hFFFF);
      n = 1;
      bad_ready = rq1_ready;
      for (int k = 0; k < 2000; k++) begin
         @(negedge UserCLK);
         #1;
         if (!clear_busy) break;
         n++;
         bad_ready |= rq1_ready;
      end
      check("clear busy cycles", n, 1024);
      check("ready during clear", bad_ready, 0);
      check("ready after clear", rq1_ready, 1);
      q1.push_back('{16'h0000, cyc + 1});
      @(posedge UserCLK);
      #1 rq1_valid = 1'b0;
      do_req(1, 0, 10'd1023, 16'h0, 16'h0, 16'h0000);

      // Reset mid-clear; pointer is left at rq1 first so reset must restore it.
      do_req(0, 1, 10'd1000, 16'hA5A5, 16'hFFFF, 16'h0);
      @(negedge UserCLK);
      clear_start = 1'b1;
      @(negedge UserCLK);
      clear_start = 1'b0;
      repeat (299) @(negedge UserCLK);
      #1;
      check("busy before reset", clear_busy, 1);
      RESET_N = 1'b0;
      rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 10'd1000;
      rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 10'd3;
      #1;
      check("rst busy", clear_busy, 0);
      check("rst men", sram_men, 0);
      check("rst rs0", rs0_valid, 0);
      check("rst rs1", rs1_valid, 0);
      check("rst ready0", rq0_ready, 0);
      @(negedge UserCLK);
      RESET_N = 1'b1;
      #1;
      check("post rst ready0", rq0_ready, 1);
      check("post rst ready1", rq1_ready, 0);
      q0.push_back('{16'hA5A5, cyc + 1});
      @(posedge UserCLK);
      #1 rq0_valid = 1'b0;
      @(negedge UserCLK);
      #1;
      check("post rst next ready1", rq1_ready, 1);
      q1.push_back('{16'h0000, cyc + 1});
      @(posedge UserCLK);
      #1 rq1_valid = 1'b0;

      repeat (3) @(negedge UserCLK);
      #1;
      check("q0 drained", q0.size(), 0);
      check("q1 drained", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
